// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline; owns no datapath.
// Latency: all hold/bubble controls are combinational from the current inputs and FSM state.
// Backpressure: a pending data-memory access freezes every stage up to EX/MEM until mem_ack.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_* source registers of the instruction in ID
//   ex_is_load/ex_reg_wr/ex_waddr   destination info of the instruction in EX
//   ex_mdu_start          EX holds a mult/div op in its first EX cycle
//   ex_br_taken           branch/jump resolved taken in EX
//   mem_req/mem_ack       data-memory handshake of the MEM stage
//   *_stall/*_flush       hold/bubble controls for PC, IF/ID, ID/EX, EX/MEM
//   mdu_busy              multi-cycle MDU op is occupying EX beyond its issue cycle
//   mem_err               sticky memory-timeout flag
//   stall_cnt             free-running count of PC-stall cycles (wraps)
module pipeline_ctrl #(
    parameter int unsigned MDU_CYCLES  = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_is_load,
    input  logic        ex_reg_wr,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_mdu_start,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        ex_mem_flush,
    output logic        mdu_busy,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    // The MDU counter only needs to hold MDU_CYCLES-2 (the issue cycle is spent in RUN,
    // the final cycle is the one where the counter reads zero).
    localparam int unsigned MDU_CW = ($clog2(MDU_CYCLES - 1) > 0) ? $clog2(MDU_CYCLES - 1) : 1;
    localparam int unsigned TMO_W  = ($clog2(MEM_TIMEOUT + 1) > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_CYCLES - 2);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [MDU_CW-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic mdu_hold;
    logic rs_hit;
    logic rt_hit;
    logic load_use;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign mem_stall = mem_req & ~mem_ack;

    // The issue cycle (RUN with ex_mdu_start) already holds the front end, so the
    // op occupies EX for the full MDU_CYCLES without a gap between RUN and MDU_WAIT.
    assign mdu_hold  = (state_q == MDU_WAIT) | ((state_q == RUN) & ex_mdu_start);

    // $0 is hard-wired, so a load "targeting" it never creates a dependency.
    assign rs_hit    = id_uses_rs & (id_rs == ex_waddr);
    assign rt_hit    = id_uses_rt & (id_rt == ex_waddr);
    assign load_use  = ex_is_load & ex_reg_wr & (ex_waddr != 5'd0) & (rs_hit | rt_hit);

    // ------------------------------------------------------------------
    // Next state, counters and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mdu_cnt_d    = mdu_cnt_q;
        tmo_cnt_d    = '0;
        mem_err_d    = mem_err_q;

        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_busy     = 1'b0;

        // FSM: a memory stall freezes the MDU sequence, since the op cannot leave
        // EX while EX/MEM is being held.
        if (!mem_stall) begin
            case (state_q)
                RUN: begin
                    if (ex_mdu_start) begin
                        state_d   = MDU_WAIT;
                        mdu_cnt_d = MDU_LOAD;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        mdu_cnt_d = mdu_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Timeout counter saturates so a very long wait cannot wrap it back under
        // the threshold; the flag latches on the edge that closes the last allowed
        // wait cycle and the stall itself carries on until the ack arrives.
        if (mem_stall) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TMO_LAST) begin
                mem_err_d = 1'b1;
            end
        end

        // Control rows in priority order. Everything is forced low while rst is
        // asserted so the stage registers see a clean pipeline during reset.
        if (!rst) begin
            mdu_busy = (state_q == MDU_WAIT);
            if (mem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (mdu_hold) begin
                // MDU ops never branch, so ex_br_taken is ignored here. The bubble
                // into EX/MEM keeps MEM/WB idle until the result is ready.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (ex_br_taken) begin
                // The instruction in ID is on the wrong path, so any load-use
                // interlock it would cause is moot.
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                // One bubble is enough: next cycle the load is in MEM and its data
                // reaches EX through the forwarding path.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end

        stall_cnt_d = pc_stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            mdu_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MDU_CYCLES=4, MEM_TIMEOUT=8).
// Each cycle pushes the expected control vector to a scoreboard; it is popped and compared mid-cycle.
// stall_cnt is checked against a bench-side count of expected PC-stall cycles.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_is_load;
    logic        ex_reg_wr;
    logic [4:0]  ex_waddr;
    logic        ex_mdu_start;
    logic        ex_br_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_stall;
    logic        ex_mem_flush;
    logic        mdu_busy;
    logic        mem_err;
    logic [31:0] stall_cnt;

    pipeline_ctrl #(
        .MDU_CYCLES  (4),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_is_load   (ex_is_load),
        .ex_reg_wr    (ex_reg_wr),
        .ex_waddr     (ex_waddr),
        .ex_mdu_start (ex_mdu_start),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .ex_mem_flush (ex_mem_flush),
        .mdu_busy     (mdu_busy),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //             ex_mem_stall, ex_mem_flush, mdu_busy, mem_err
    localparam logic [8:0] NONE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] LU   = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] BR   = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] MDU0 = 9'b1_1_0_1_0_0_1_0_0;
    localparam logic [8:0] MDUW = 9'b1_1_0_1_0_0_1_1_0;
    localparam logic [8:0] MEM  = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] MEMW = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] ERR  = 9'b0_0_0_0_0_0_0_0_1;

    logic [40:0] exp_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_cnt = 32'd0;

    // One cycle: inputs already driven (just after the rising edge); push the
    // expectation, compare at the falling edge, then advance to the next cycle.
    task automatic cyc(input string tag, input logic [8:0] flags);
        logic [40:0] obs;
        logic [40:0] exp;
        string       t;
        exp_q.push_back({flags, model_cnt});
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mdu_busy, mem_err, stall_cnt};
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed flags=%b stall_cnt=%0d, expected flags=%b stall_cnt=%0d",
                   t, obs[40:32], obs[31:0], exp[40:32], exp[31:0]);
        end
        if (rst) model_cnt = 32'd0;
        else if (flags[8]) model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_is_load = 1'b0; ex_reg_wr = 1'b0; ex_waddr = 5'd0;
        ex_mdu_start = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---- Reset: every hazard source active, all controls must stay low
        clear_inputs();
        rst = 1'b1;
        ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_waddr = 5'd5;
        id_rs = 5'd5; id_uses_rs = 1'b1; ex_mdu_start = 1'b1;
        ex_br_taken = 1'b1; mem_req = 1'b1;
        @(posedge clk); #1;
        cyc("reset_gated", NONE);
        cyc("reset_hold", NONE);
        rst = 1'b0;
        clear_inputs();
        cyc("idle", NONE);

        // ---- Load-use on rs, exactly one bubble
        ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_waddr = 5'd5;
        id_rs = 5'd5; id_uses_rs = 1'b1;
        cyc("lu_rs", LU);
        ex_is_load = 1'b0; ex_reg_wr = 1'b0;
        cyc("lu_rs_release", NONE);

        // ---- Load-use on rt
        clear_inputs();
        ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_waddr = 5'd7;
        id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
        cyc("lu_rt", LU);
        clear_inputs();
        cyc("lu_rt_release", NONE);

        // ---- Non-hazards
        ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_waddr = 5'd0;
        id_rs = 5'd0; id_uses_rs = 1'b1;
        cyc("lu_waddr0", NONE);
        ex_waddr = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b0;
        cyc("lu_rs_unused", NONE);
        id_uses_rs = 1'b1; ex_reg_wr = 1'b0;
        cyc("lu_no_regwr", NONE);
        ex_reg_wr = 1'b1; ex_is_load = 1'b0;
        cyc("alu_no_interlock", NONE);

        // ---- Branch squashes a load-use match
        ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_waddr = 5'd5;
        id_rs = 5'd5; id_uses_rs = 1'b1; ex_br_taken = 1'b1;
        cyc("br_over_lu", BR);
        clear_inputs();
        cyc("br_after", NONE);
        ex_br_taken = 1'b1;
        cyc("br_alone", BR);
        clear_inputs();

        // ---- MDU op: 4 held cycles, busy for last 3, branch ignored while held
        ex_mdu_start = 1'b1;
        cyc("mdu_issue", MDU0);
        ex_mdu_start = 1'b0; ex_br_taken = 1'b1;
        cyc("mdu_w1", MDUW);
        ex_br_taken = 1'b0;
        cyc("mdu_w2", MDUW);
        cyc("mdu_w3", MDUW);
        cyc("mdu_done", NONE);

        // ---- Memory wait: 3 stall cycles, released on the ack cycle
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("mem_wait%0d", i), MEM);
        mem_ack = 1'b1;
        cyc("mem_ack", NONE);
        clear_inputs();
        cyc("mem_idle", NONE);

        // ---- Memory wait during MDU_WAIT extends the hold by 3 cycles
        ex_mdu_start = 1'b1;
        cyc("mdum_issue", MDU0);
        ex_mdu_start = 1'b0;
        cyc("mdum_w1", MDUW);
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("mdum_mem%0d", i), MEMW);
        mem_ack = 1'b1;
        cyc("mdum_w2", MDUW);
        clear_inputs();
        cyc("mdum_w3", MDUW);
        cyc("mdum_done", NONE);

        // ---- Memory stall outranks an MDU issue; the op issues after the ack
        ex_mdu_start = 1'b1; mem_req = 1'b1; mem_ack = 1'b0;
        cyc("mem_over_issue", MEM);
        mem_req = 1'b0;
        cyc("issue_after_mem", MDU0);
        ex_mdu_start = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("issue_w%0d", i), MDUW);
        cyc("issue_done", NONE);

        // ---- Timeout: 10 wait cycles, flag visible from the 9th, sticky after ack
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 1; i <= 8; i++) cyc($sformatf("tmo_c%0d", i), MEM);
        cyc("tmo_c9", MEM | ERR);
        cyc("tmo_c10", MEM | ERR);
        mem_ack = 1'b1;
        cyc("tmo_ack", ERR);
        clear_inputs();
        cyc("tmo_sticky1", ERR);
        cyc("tmo_sticky2", ERR);

        // ---- Reset in the middle of MDU_WAIT
        ex_mdu_start = 1'b1;
        cyc("rstm_issue", MDU0 | ERR);
        ex_mdu_start = 1'b0;
        cyc("rstm_w1", MDUW | ERR);
        rst = 1'b1;
        cyc("rstm_in_reset", ERR);
        rst = 1'b0;
        cyc("rstm_after", NONE);
        cyc("rstm_run", NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
